// File: rtl/thumb_packer.sv
// Thumb instruction-stream packer: folds 16/32-bit instructions into
// aligned 32-bit memory words, earlier halfword in [31:16].
module thumb_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] NOP       = 16'hbf00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is32,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        flush_done,
    output logic        err,
    output logic [15:0] word_cnt
);

    logic        half_valid;
    logic [15:0] half_data;
    logic        flush_pend;
    logic [31:0] next_addr;

    logic        acc;
    logic        out_free;
    logic        fl_req;
    logic        do_flush;
    logic        emit;
    logic [31:0] emit_data;
    logic        half_v_nxt;
    logic [15:0] half_d_nxt;
    logic [15:0] hw_first;
    logic        is_pref;

    assign in_ready = !flush_pend && (!out_valid || out_ready);

    // Decide what this cycle emits and what stays pending; an accept
    // always wins over a flush, which then waits one cycle.
    always_comb begin
        acc        = in_valid && in_ready;
        out_free   = !out_valid || out_ready;
        fl_req     = flush || flush_pend;
        do_flush   = fl_req && out_free && !acc;
        hw_first   = in_is32 ? in_instr[31:16] : in_instr[15:0];
        is_pref    = (hw_first[15:13] == 3'b111)
                  && (hw_first[12:11] != 2'b00);
        emit       = 1'b0;
        emit_data  = '0;
        half_v_nxt = half_valid;
        half_d_nxt = half_data;
        if (acc) begin
            case ({half_valid, in_is32})
                2'b00: begin
                    half_v_nxt = 1'b1;
                    half_d_nxt = in_instr[15:0];
                end
                2'b01: begin
                    emit      = 1'b1;
                    emit_data = in_instr;
                end
                2'b10: begin
                    emit       = 1'b1;
                    emit_data  = {half_data, in_instr[15:0]};
                    half_v_nxt = 1'b0;
                end
                default: begin
                    emit       = 1'b1;
                    emit_data  = {half_data, in_instr[31:16]};
                    half_d_nxt = in_instr[15:0];
                end
            endcase
        end else if (do_flush && half_valid) begin
            emit       = 1'b1;
            emit_data  = {half_data, NOP};
            half_v_nxt = 1'b0;
        end
    end

    // Pending-halfword, flush and output-register state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            half_valid <= 1'b0;
            half_data  <= '0;
            flush_pend <= 1'b0;
            next_addr  <= BASE_ADDR;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            flush_done <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
        end else begin
            half_valid <= half_v_nxt;
            half_data  <= half_d_nxt;
            flush_pend <= fl_req && !do_flush;
            flush_done <= do_flush;
            if (acc && (is_pref != in_is32)) begin
                err <= 1'b1;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_addr  <= next_addr;
                out_data  <= emit_data;
                next_addr <= next_addr + 32'd4;
                word_cnt  <= word_cnt + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_thumb_packer.sv
// Directed-vector bench for thumb_packer, with a second instance
// built at the top of the address space to exercise wrap-around.
module tb_thumb_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_is32;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] out_addr,  out_addr2;
    logic [31:0] out_data,  out_data2;
    logic        flush_done, flush_done2;
    logic        err,       err2;
    logic [15:0] word_cnt,  word_cnt2;

    int checks = 0;
    int errors = 0;

    thumb_packer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is32(in_is32), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .flush_done(flush_done), .err(err),
        .word_cnt(word_cnt)
    );

    thumb_packer #(.BASE_ADDR(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_is32(in_is32), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_addr(out_addr2), .out_data(out_data2),
        .flush_done(flush_done2), .err(err2),
        .word_cnt(word_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic        s;
        logic [31:0] ins;
        logic        f;
        logic        o;
        logic        rdy;
        logic        ov;
        logic [31:0] oa;
        logic [31:0] od;
        logic        fd;
        logic        er;
        logic [15:0] wc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic r, v, s, input logic [31:0] ins,
        input logic f, o, rdy, ov,
        input logic [31:0] oa, od,
        input logic fd, er, input logic [15:0] wc);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.ins = ins; t.f = f; t.o = o;
        t.rdy = rdy; t.ov = ov; t.oa = oa; t.od = od;
        t.fd = fd; t.er = er; t.wc = wc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, v, s, input logic [31:0] ins,
                         input logic f, o);
        rst_n     = !r;
        in_valid  = v;
        in_is32   = s;
        in_instr  = ins;
        flush     = f;
        out_ready = o;
    endtask

    task automatic step(input logic r, v, s, input logic [31:0] ins,
                        input logic f, o);
        @(negedge clk);
        drive(r, v, s, ins, f, o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // r v s ins f o | rdy ov oa od fd er wc
        // A: two 16-bit halves form one word
        tv.push_back(mk(0,1,0,32'h2001,0,1, 1,0,32'h0,32'h0,0,0,0));
        tv.push_back(mk(0,1,0,32'h2102,0,1, 1,1,32'h0,32'h20012102,0,0,1));
        tv.push_back(mk(0,0,0,32'h0,0,1,    1,0,32'h0,32'h20012102,0,0,1));
        tv.push_back(mk(1,0,0,32'h0,0,1,    1,0,32'h0,32'h0,0,0,0));
        // B: 32-bit from empty, then 16-bit with flush
        tv.push_back(mk(0,1,1,32'hF000F800,0,1, 1,1,32'h0,32'hF000F800,0,0,1));
        tv.push_back(mk(0,1,0,32'h4770,1,1, 1,0,32'h0,32'hF000F800,0,0,1));
        tv.push_back(mk(0,0,0,32'h0,0,1,    0,1,32'h4,32'h4770BF00,1,0,2));
        tv.push_back(mk(0,0,0,32'h0,0,1,    1,0,32'h4,32'h4770BF00,0,0,2));
        // C: straddling 32-bit, then empty flush
        tv.push_back(mk(1,0,0,32'h0,0,1,    1,0,32'h0,32'h0,0,0,0));
        tv.push_back(mk(0,1,0,32'h2001,0,1, 1,0,32'h0,32'h0,0,0,0));
        tv.push_back(mk(0,1,1,32'hF000F800,0,1, 1,1,32'h0,32'h2001F000,0,0,1));
        tv.push_back(mk(0,1,0,32'h4770,0,1, 1,1,32'h4,32'hF8004770,0,0,2));
        tv.push_back(mk(0,0,0,32'h0,1,1,    1,0,32'h4,32'hF8004770,1,0,2));
        tv.push_back(mk(0,0,0,32'h0,0,1,    1,0,32'h4,32'hF8004770,0,0,2));
        // D: output stall, then flush during stall
        tv.push_back(mk(1,0,0,32'h0,0,1,    1,0,32'h0,32'h0,0,0,0));
        tv.push_back(mk(0,1,1,32'hE8001111,0,0, 1,1,32'h0,32'hE8001111,0,0,1));
        tv.push_back(mk(0,1,1,32'hF1234567,0,0, 0,1,32'h0,32'hE8001111,0,0,1));
        tv.push_back(mk(0,1,1,32'hF1234567,0,0, 0,1,32'h0,32'hE8001111,0,0,1));
        tv.push_back(mk(0,1,1,32'hF1234567,0,0, 0,1,32'h0,32'hE8001111,0,0,1));
        tv.push_back(mk(0,1,1,32'hF1234567,0,1, 1,1,32'h4,32'hF1234567,0,0,2));
        tv.push_back(mk(0,0,0,32'h0,0,1,    1,0,32'h4,32'hF1234567,0,0,2));
        tv.push_back(mk(0,1,0,32'h2001,0,1, 1,0,32'h4,32'hF1234567,0,0,2));
        tv.push_back(mk(0,1,0,32'h3003,0,1, 1,1,32'h8,32'h20013003,0,0,3));
        tv.push_back(mk(0,1,0,32'h4004,1,0, 0,1,32'h8,32'h20013003,0,0,3));
        tv.push_back(mk(0,1,0,32'h4004,0,0, 0,1,32'h8,32'h20013003,0,0,3));
        tv.push_back(mk(0,1,0,32'h4004,0,1, 0,0,32'h8,32'h20013003,1,0,3));
        tv.push_back(mk(0,1,0,32'h4004,0,1, 1,0,32'h8,32'h20013003,0,0,3));
        // E: prefix as 16-bit sets sticky err; reset drops pending half
        tv.push_back(mk(1,0,0,32'h0,0,1,    1,0,32'h0,32'h0,0,0,0));
        tv.push_back(mk(0,1,0,32'hF000,0,1, 1,0,32'h0,32'h0,0,1,0));
        tv.push_back(mk(0,0,0,32'h0,0,1,    1,0,32'h0,32'h0,0,1,0));
        tv.push_back(mk(0,1,0,32'h2001,0,1, 1,1,32'h0,32'hF0002001,0,1,1));
        tv.push_back(mk(0,1,0,32'h7007,0,1, 1,0,32'h0,32'hF0002001,0,1,1));
        tv.push_back(mk(1,0,0,32'h0,0,1,    1,0,32'h0,32'h0,0,0,0));
        tv.push_back(mk(0,0,0,32'h0,1,1,    1,0,32'h0,32'h0,1,0,0));
        // F: 32-bit flag on a non-prefix first halfword
        tv.push_back(mk(1,0,0,32'h0,0,1,    1,0,32'h0,32'h0,0,0,0));
        tv.push_back(mk(0,1,1,32'h12345678,0,1, 1,1,32'h0,32'h12345678,0,1,1));
        tv.push_back(mk(1,0,0,32'h0,0,1,    1,0,32'h0,32'h0,0,0,0));

        drive(1, 0, 0, 32'h0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst ov", out_valid, 0);
        chk("rst oa", out_addr, 0);
        chk("rst od", out_data, 0);
        chk("rst fd", flush_done, 0);
        chk("rst err", err, 0);
        chk("rst wc", word_cnt, 0);
        chk("rst rdy", in_ready, 1);
        chk("rst oa2", out_addr2, 0);
        @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].r, tv[i].v, tv[i].s, tv[i].ins,
                  tv[i].f, tv[i].o);
            #1;
            chk($sformatf("v%0d rdy", i), in_ready, tv[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ov", i), out_valid, tv[i].ov);
            chk($sformatf("v%0d oa", i), out_addr, tv[i].oa);
            chk($sformatf("v%0d od", i), out_data, tv[i].od);
            chk($sformatf("v%0d fd", i), flush_done, tv[i].fd);
            chk($sformatf("v%0d err", i), err, tv[i].er);
            chk($sformatf("v%0d wc", i), word_cnt, tv[i].wc);
            @(negedge clk);
        end

        // Address wrap on the high-base instance
        step(1, 0, 0, 32'h0, 0, 1);
        step(0, 1, 0, 32'h2001, 0, 1);
        chk("w0 ov", out_valid2, 0);
        step(0, 1, 0, 32'h2102, 0, 1);
        chk("w1 ov", out_valid2, 1);
        chk("w1 oa", out_addr2, 32'hFFFF_FFFC);
        chk("w1 od", out_data2, 32'h20012102);
        step(0, 1, 0, 32'h3003, 0, 1);
        step(0, 1, 0, 32'h4004, 0, 1);
        chk("w2 ov", out_valid2, 1);
        chk("w2 oa", out_addr2, 32'h0);
        chk("w2 od", out_data2, 32'h30034004);
        chk("w2 wc", word_cnt2, 2);
        step(0, 1, 0, 32'h5005, 0, 1);
        chk("w3 ov", out_valid2, 0);
        step(1, 0, 0, 32'h0, 0, 1);
        chk("wr ov", out_valid2, 0);
        chk("wr oa", out_addr2, 0);
        chk("wr od", out_data2, 0);
        chk("wr fd", flush_done2, 0);
        chk("wr err", err2, 0);
        chk("wr wc", word_cnt2, 0);
        chk("wr rdy", in_ready2, 1);
        step(0, 0, 0, 32'h0, 1, 1);
        chk("wf fd", flush_done2, 1);
        chk("wf ov", out_valid2, 0);
        chk("wf wc", word_cnt2, 0);
        step(0, 1, 0, 32'h6006, 0, 1);
        step(0, 1, 0, 32'h7007, 0, 1);
        chk("wn oa", out_addr2, 32'hFFFF_FFFC);
        chk("wn od", out_data2, 32'h60067007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/thumb_packer.md
# thumb_packer

Instruction-stream packer for the Thumb fetch path. It accepts a stream of decoded 16-bit and 32-bit Thumb instructions and packs them, in program order, into aligned 32-bit instruction-memory words. Packing follows the fetch splitter's halfword order: the earlier halfword goes in bits [31:16], the later one in bits [15:0]. A 32-bit instruction may straddle two words. It sits between the program loader/assembler front-end and the instruction memory write port.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
- NOP, 16'hbf00, halfword used to pad a partial word on flush.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  instruction offered.
- in_ready  output  1  instruction accepted when in_valid && in_ready.
- in_is32  input  1  1 = 32-bit instruction, 0 = 16-bit.
- in_instr  input  32  16-bit: instr in [15:0], [31:16] ignored. 32-bit: first halfword (hw1) in [31:16], second (hw2) in [15:0].
- flush  input  1  single-cycle request to emit any pending halfword padded with NOP.
- out_valid  output  1  memory word valid.
- out_ready  input  1  memory accepts word when out_valid && out_ready.
- out_addr  output  32  byte address of word.
- out_data  output  32  packed word.
- flush_done  output  1  one-cycle pulse when flush completes.
- err  output  1  sticky encoding mismatch flag.
- word_cnt  output  16  words emitted since reset, wraps at 2^16.

## Operation
- State: half_valid/half_data (one pending halfword), flush_pend, next_addr (init BASE_ADDR), and an output register (out_valid/out_addr/out_data).
- in_ready = !flush_pend && (!out_valid || out_ready).
- Accept rules:
  - Empty + 16-bit: store instr[15:0] in half; no word emitted.
  - Empty + 32-bit: emit {hw1, hw2}.
  - Half + 16-bit: emit {half, instr[15:0]}, then clear half.
  - Half + 32-bit: emit {half, hw1}, then store hw2 as half (half_valid stays 1).
- Emitting loads out_data and sets out_addr = next_addr and out_valid = 1. It also does next_addr += 4 (mod 2^32) and word_cnt += 1.
- out_valid clears on out_ready when nothing new is emitted the same cycle. Back-to-back emission is allowed.
- Prefix check: an instruction whose first halfword has [15:13]==3'b111 && [12:11]!=2'b00 is a 32-bit prefix. For 16-bit inputs the first halfword is instr[15:0]; for 32-bit inputs it is hw1.
  - If prefix status disagrees with in_is32, set err = 1 (sticky until reset).
  - Packing still follows in_is32.
- Flush:
  - A flush pulse sets flush_pend. A flush in the same cycle as an accept is latched, and the accepted instruction is processed first.
  - When flush_pend is set and the output register is free, and half_valid = 1: emit {half, NOP} and clear half.
  - In either case that cycle, clear flush_pend and pulse flush_done.
  - Flush with nothing pending emits no word.
  - A flush arriving while flush_pend is already set merges into it.

## Timing
- Reset values (rst_n = 0 at posedge): out_valid 0, out_addr 0, out_data 0, flush_done 0, err 0, word_cnt 0, half_valid 0, flush_pend 0, next_addr BASE_ADDR. in_ready is 1 after reset.
- Latency: an emitting accept in cycle N gives out_valid = 1 in cycle N+1.
- Throughput: one instruction per cycle while out_ready = 1.
- Flush timing:
  - flush in cycle N with the output register free: padded word visible in cycle N+1, together with flush_done.
  - If the output register is stalled: the flush waits, and in_ready stays 0 until flush_done.
- out_addr/out_data hold stable while out_valid && !out_ready.
- next_addr wraps from 32'hFFFF_FFFC to 0 with no special handling.
- Reset mid-operation discards any pending halfword and any pending flush.

## Test plan
- 16-bit 16'h2001, then 16'h2102, with out_ready = 1 -> one word {2001, 2102} at BASE_ADDR. word_cnt = 1, no err.
- 32-bit 32'hF000_F800 from empty -> word 32'hF000F800 at addr 0. Then 16'h4770 + flush -> word 32'h4770BF00 at addr 4, and flush_done pulses.
- 16'h2001, then 32'hF000_F800, then 16'h4770 -> words 32'h2001F000 @0 and 32'hF8004770 @4. Nothing pending after.
- Hold out_ready = 0 for 3 cycles with words queued -> in_ready = 0 and outputs stable. Release -> no word lost or duplicated.
- in_is32 = 0 with instr 16'hF000 -> err = 1 and it stays 1. Flush with nothing pending -> flush_done, no word.
- BASE_ADDR = 32'hFFFF_FFFC, two full words -> addresses FFFFFFFC then 00000000. Assert rst_n = 0 with a half pending -> all outputs return to reset values.
